// File: rtl/segre_hazard_unit_pkg.sv
// Shared types and constants for the Segre hazard unit: forwarding select
// encoding and the stage indices of the forwarding network.
package segre_pkg;

  localparam int NUM_FWD_DEF = 3;
  localparam int FWD_SEL_W   = $clog2(NUM_FWD_DEF + 1);

  typedef logic [FWD_SEL_W-1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF = FWD_SEL_W'(0);

  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

endpackage

// File: rtl/segre_hazard_unit_if.sv
// Pipeline-to-hazard-unit bundle: ID operands, downstream stage state,
// long-latency issue/complete and the resulting control outputs.
interface segre_hazard_unit_if
  import segre_pkg::*;
#(
  parameter int REG_SIZE = 5,
  parameter int NUM_SRC  = 2,
  parameter int NUM_FWD  = NUM_FWD_DEF,
  parameter int CNT_W    = 32
);
  localparam int FSW = $clog2(NUM_FWD + 1);

  logic                        ic_hit_i;
  logic                        valid_if_i;
  logic                        valid_id_i;
  logic [NUM_SRC*REG_SIZE-1:0] src_id_i;
  logic [NUM_SRC-1:0]          src_used_id_i;
  logic [NUM_FWD-1:0]          valid_stg_i;
  logic [NUM_FWD-1:0]          we_stg_i;
  logic [NUM_FWD*REG_SIZE-1:0] dst_stg_i;
  logic [NUM_FWD-1:0]          rdy_stg_i;
  logic                        issue_long_i;
  logic [REG_SIZE-1:0]         issue_dst_i;
  logic                        complete_long_i;
  logic [REG_SIZE-1:0]         complete_dst_i;
  logic                        branch_taken_i;
  logic                        block_if_o;
  logic                        block_id_o;
  logic                        inject_nops_id_o;
  logic                        inject_nops_ex_o;
  logic [NUM_SRC*FSW-1:0]      fwd_sel_o;
  logic                        issue_ok_o;
  logic [CNT_W-1:0]            stall_cnt_o;
  logic [CNT_W-1:0]            miss_cnt_o;

  modport master (
    output ic_hit_i, valid_if_i, valid_id_i, src_id_i, src_used_id_i,
           valid_stg_i, we_stg_i, dst_stg_i, rdy_stg_i, issue_long_i,
           issue_dst_i, complete_long_i, complete_dst_i, branch_taken_i,
    input  block_if_o, block_id_o, inject_nops_id_o, inject_nops_ex_o,
           fwd_sel_o, issue_ok_o, stall_cnt_o, miss_cnt_o
  );

  modport slave (
    input  ic_hit_i, valid_if_i, valid_id_i, src_id_i, src_used_id_i,
           valid_stg_i, we_stg_i, dst_stg_i, rdy_stg_i, issue_long_i,
           issue_dst_i, complete_long_i, complete_dst_i, branch_taken_i,
    output block_if_o, block_id_o, inject_nops_id_o, inject_nops_ex_o,
           fwd_sel_o, issue_ok_o, stall_cnt_o, miss_cnt_o
  );

endinterface

// File: rtl/segre_hazard_unit_scoreboard.sv
// Pending-write scoreboard for long-latency ops: one bit per register,
// clear on completion then set on issue, with combinational lookups.
module segre_scoreboard
  import segre_pkg::*;
#(
  parameter int REG_SIZE = 5,
  parameter int NUM_REGS = 32,
  parameter int NUM_LK   = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       set_en,
  input  logic [REG_SIZE-1:0]        set_dst,
  input  logic                       clr_en,
  input  logic [REG_SIZE-1:0]        clr_dst,
  input  logic [NUM_LK*REG_SIZE-1:0] lk_addr,
  output logic [NUM_LK-1:0]          lk_pend
);

  logic [NUM_REGS-1:0] pending_r;
  logic [NUM_REGS-1:0] pend_nxt_s;

  // Next pending vector: set is applied after clear so it wins on a collision.
  always_comb begin
    pend_nxt_s = pending_r;
    if (clr_en && (clr_dst != {REG_SIZE{1'b0}})) begin
      pend_nxt_s[clr_dst] = 1'b0;
    end else begin
      pend_nxt_s = pend_nxt_s;
    end
    if (set_en && (set_dst != {REG_SIZE{1'b0}})) begin
      pend_nxt_s[set_dst] = 1'b1;
    end else begin
      pend_nxt_s = pend_nxt_s;
    end
  end

  // Pending bit state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_r <= {NUM_REGS{1'b0}};
    end else begin
      pending_r <= pend_nxt_s;
    end
  end

  // Per-port lookup of the registered state.
  always_comb begin
    lk_pend = {NUM_LK{1'b0}};
    for (int i = 0; i < NUM_LK; i++) begin
      lk_pend[i] = pending_r[lk_addr[i*REG_SIZE +: REG_SIZE]];
    end
  end

endmodule

// File: rtl/segre_hazard_unit.sv
// Segre IF/ID hazard controller: RAW detection with forwarding selection,
// long-latency scoreboard, branch flush and saturating perf counters.
module segre_hazard_unit
  import segre_pkg::*;
#(
  parameter int REG_SIZE = 5,
  parameter int NUM_REGS = 32,
  parameter int NUM_SRC  = 2,
  parameter int NUM_FWD  = NUM_FWD_DEF,
  parameter int CNT_W    = 32
) (
  input logic              clk_i,
  input logic              rst_i,
  segre_hazard_unit_if.slave bus
);

  localparam int FSW = $clog2(NUM_FWD + 1);
  localparam int LKN = NUM_SRC + 1;

  logic [LKN*REG_SIZE-1:0] lk_addr_s;
  logic [LKN-1:0]          lk_pend_s;
  logic [NUM_SRC*FSW-1:0]  fwd_sel_s;
  logic                    src_stall_s;
  logic                    waw_s;
  logic                    data_stall_s;
  logic                    ic_miss_s;
  logic                    flush_s;
  logic                    block_id_s;
  logic                    issue_ok_s;
  logic [CNT_W-1:0]        stall_cnt_r;
  logic [CNT_W-1:0]        miss_cnt_r;

  // Scoreboard lookups: all ID sources, plus the long-op destination for WAW.
  always_comb begin
    lk_addr_s = {LKN*REG_SIZE{1'b0}};
    lk_addr_s[NUM_SRC*REG_SIZE-1:0] = bus.src_id_i;
    lk_addr_s[NUM_SRC*REG_SIZE +: REG_SIZE] = bus.issue_dst_i;
  end

  segre_scoreboard #(
    .REG_SIZE (REG_SIZE),
    .NUM_REGS (NUM_REGS),
    .NUM_LK   (LKN)
  ) u_scoreboard (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .set_en  (issue_ok_s),
    .set_dst (bus.issue_dst_i),
    .clr_en  (bus.complete_long_i),
    .clr_dst (bus.complete_dst_i),
    .lk_addr (lk_addr_s),
    .lk_pend (lk_pend_s)
  );

  // Per-source RAW check; stages scanned oldest-first so the youngest match wins.
  always_comb begin
    logic [REG_SIZE-1:0] src_v;
    logic                hit_v;
    logic                hit_rdy_v;
    logic [FSW-1:0]      sel_v;
    logic                cover_v;
    fwd_sel_s   = {NUM_SRC*FSW{1'b0}};
    src_stall_s = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      src_v     = bus.src_id_i[s*REG_SIZE +: REG_SIZE];
      hit_v     = 1'b0;
      hit_rdy_v = 1'b0;
      sel_v     = {FSW{1'b0}};
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (bus.valid_stg_i[k] && bus.we_stg_i[k] &&
            (bus.dst_stg_i[k*REG_SIZE +: REG_SIZE] == src_v)) begin
          hit_v     = 1'b1;
          hit_rdy_v = bus.rdy_stg_i[k];
          sel_v     = FSW'(k + 1);
        end else begin
          hit_v     = hit_v;
        end
      end
      cover_v = bus.complete_long_i && (bus.complete_dst_i == src_v);
      if (bus.src_used_id_i[s] && (src_v != {REG_SIZE{1'b0}})) begin
        fwd_sel_s[s*FSW +: FSW] = sel_v;
        if ((hit_v && !hit_rdy_v) || (lk_pend_s[s] && !cover_v)) begin
          src_stall_s = 1'b1;
        end else begin
          src_stall_s = src_stall_s;
        end
      end else begin
        fwd_sel_s[s*FSW +: FSW] = {FSW{1'b0}};
      end
    end
  end

  assign waw_s = bus.issue_long_i && lk_pend_s[NUM_SRC] &&
                 !(bus.complete_long_i && (bus.complete_dst_i == bus.issue_dst_i));
  assign data_stall_s = bus.valid_id_i && (src_stall_s || waw_s);
  assign ic_miss_s    = bus.valid_if_i && !bus.ic_hit_i;
  assign flush_s      = bus.branch_taken_i;
  assign block_id_s   = data_stall_s && !flush_s;
  assign issue_ok_s   = bus.issue_long_i && bus.valid_id_i && !data_stall_s && !flush_s &&
                        (bus.issue_dst_i != {REG_SIZE{1'b0}});

  // A taken branch redirects fetch, so it also drops the data-stall hold on IF.
  assign bus.block_if_o       = block_id_s || ic_miss_s;
  assign bus.block_id_o       = block_id_s;
  assign bus.inject_nops_id_o = ic_miss_s || flush_s;
  assign bus.inject_nops_ex_o = data_stall_s || flush_s;
  assign bus.fwd_sel_o        = fwd_sel_s;
  assign bus.issue_ok_o       = issue_ok_s;
  assign bus.stall_cnt_o      = stall_cnt_r;
  assign bus.miss_cnt_o       = miss_cnt_r;

  // Saturating stall and I$ miss counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      miss_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      if (block_id_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
      if (ic_miss_s && (miss_cnt_r != {CNT_W{1'b1}})) begin
        miss_cnt_r <= miss_cnt_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_segre_hazard_unit.sv
// Directed bench for segre_hazard_unit: forwarding, load-use, scoreboard,
// flush, I$ miss counting, async reset and counter saturation.
module tb_segre_hazard_unit;
  import segre_pkg::*;

  localparam int RS = 5;
  localparam int CW = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   exp_stall;

  segre_hazard_unit_if #(.REG_SIZE(RS), .NUM_SRC(2), .NUM_FWD(3), .CNT_W(CW)) bus ();

  segre_hazard_unit #(
    .REG_SIZE (RS),
    .NUM_REGS (32),
    .NUM_SRC  (2),
    .NUM_FWD  (3),
    .CNT_W    (CW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.valid_if_i      = 1'b0;
    bus.ic_hit_i        = 1'b1;
    bus.valid_id_i      = 1'b0;
    bus.src_id_i        = '0;
    bus.src_used_id_i   = '0;
    bus.valid_stg_i     = '0;
    bus.we_stg_i        = '0;
    bus.dst_stg_i       = '0;
    bus.rdy_stg_i       = '0;
    bus.issue_long_i    = 1'b0;
    bus.issue_dst_i     = '0;
    bus.complete_long_i = 1'b0;
    bus.complete_dst_i  = '0;
    bus.branch_taken_i  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_src(input int s, input logic [RS-1:0] r);
    bus.src_id_i[s*RS +: RS] = r;
    bus.src_used_id_i[s]     = 1'b1;
  endtask

  task automatic set_stg(input int k, input logic [RS-1:0] r, input logic rdy);
    bus.valid_stg_i[k]        = 1'b1;
    bus.we_stg_i[k]           = 1'b1;
    bus.dst_stg_i[k*RS +: RS] = r;
    bus.rdy_stg_i[k]          = rdy;
  endtask

  task automatic test_reset();
    logic [13:0] outs;
    rst = 1'b1;
    idle();
    #1;
    outs = {bus.block_if_o, bus.block_id_o, bus.inject_nops_id_o, bus.inject_nops_ex_o,
            bus.fwd_sel_o, bus.issue_ok_o, bus.stall_cnt_o, bus.miss_cnt_o[0]};
    total++;
    if (outs !== 14'd0) begin
      bad++; $display("FAIL reset_outputs got=%b want=0", outs);
    end
    total++;
    if (bus.miss_cnt_o !== 4'd0) begin
      bad++; $display("FAIL reset_miss_cnt got=%0d want=0", bus.miss_cnt_o);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic test_fwd();
    idle();
    bus.valid_id_i = 1'b1;
    set_src(0, 5'd5);
    set_stg(0, 5'd5, 1'b1);
    #1;
    total++;
    if (bus.fwd_sel_o[1:0] !== 2'd1 || bus.block_id_o !== 1'b0) begin
      bad++; $display("FAIL fwd_ex got sel=%0d blk=%b want sel=1 blk=0", bus.fwd_sel_o[1:0], bus.block_id_o);
    end
    bus.valid_stg_i[0] = 1'b0;
    set_stg(1, 5'd5, 1'b1);
    #1;
    total++;
    if (bus.fwd_sel_o[1:0] !== 2'd2 || bus.inject_nops_ex_o !== 1'b0) begin
      bad++; $display("FAIL fwd_mem got sel=%0d nex=%b want sel=2 nex=0", bus.fwd_sel_o[1:0], bus.inject_nops_ex_o);
    end
    set_stg(0, 5'd5, 1'b1);
    set_src(1, 5'd0);
    set_stg(2, 5'd0, 1'b1);
    #1;
    total++;
    if (bus.fwd_sel_o !== 4'b0001) begin
      bad++; $display("FAIL fwd_prio_r0 got=%b want=0001", bus.fwd_sel_o);
    end
    bus.src_used_id_i[0] = 1'b0;
    #1;
    total++;
    if (bus.fwd_sel_o !== 4'b0000) begin
      bad++; $display("FAIL fwd_unused got=%b want=0000", bus.fwd_sel_o);
    end
    idle();
    step();
  endtask

  task automatic test_load_use();
    idle();
    bus.valid_id_i = 1'b1;
    set_src(1, 5'd7);
    set_stg(0, 5'd7, 1'b0);
    set_stg(1, 5'd7, 1'b1);
    #1;
    total++;
    if ({bus.block_if_o, bus.block_id_o, bus.inject_nops_ex_o, bus.inject_nops_id_o} !== 4'b1110) begin
      bad++; $display("FAIL load_use_stall got=%b want=1110",
                      {bus.block_if_o, bus.block_id_o, bus.inject_nops_ex_o, bus.inject_nops_id_o});
    end
    step();
    exp_stall++;
    idle();
    bus.valid_id_i = 1'b1;
    set_src(1, 5'd7);
    set_stg(1, 5'd7, 1'b1);
    #1;
    total++;
    if (bus.fwd_sel_o[3:2] !== 2'd2 || bus.block_id_o !== 1'b0) begin
      bad++; $display("FAIL load_use_fwd got sel=%0d blk=%b want sel=2 blk=0", bus.fwd_sel_o[3:2], bus.block_id_o);
    end
    total++;
    if (bus.stall_cnt_o !== 4'd1) begin
      bad++; $display("FAIL load_use_cnt got=%0d want=1", bus.stall_cnt_o);
    end
    idle();
  endtask

  task automatic test_scoreboard();
    idle();
    bus.valid_id_i   = 1'b1;
    bus.issue_long_i = 1'b1;
    bus.issue_dst_i  = 5'd9;
    #1;
    total++;
    if (bus.issue_ok_o !== 1'b1) begin
      bad++; $display("FAIL sb_issue got=%b want=1", bus.issue_ok_o);
    end
    step();
    idle();
    bus.valid_id_i = 1'b1;
    set_src(0, 5'd9);
    for (int c = 0; c < 2; c++) begin
      #1;
      total++;
      if (bus.block_id_o !== 1'b1) begin
        bad++; $display("FAIL sb_wait cyc=%0d got=%b want=1", c, bus.block_id_o);
      end
      step();
      exp_stall++;
    end
    bus.complete_long_i = 1'b1;
    bus.complete_dst_i  = 5'd9;
    set_stg(2, 5'd9, 1'b1);
    #1;
    total++;
    if (bus.block_id_o !== 1'b0 || bus.fwd_sel_o[1:0] !== 2'd3) begin
      bad++; $display("FAIL sb_complete got blk=%b sel=%0d want blk=0 sel=3", bus.block_id_o, bus.fwd_sel_o[1:0]);
    end
    step();
    idle();
    bus.valid_id_i = 1'b1;
    set_src(0, 5'd9);
    #1;
    total++;
    if (bus.block_id_o !== 1'b0 || bus.fwd_sel_o[1:0] !== 2'd0) begin
      bad++; $display("FAIL sb_cleared got blk=%b sel=%0d want blk=0 sel=0", bus.block_id_o, bus.fwd_sel_o[1:0]);
    end
    idle();
  endtask

  task automatic test_same_cycle();
    idle();
    bus.valid_id_i   = 1'b1;
    bus.issue_long_i = 1'b1;
    bus.issue_dst_i  = 5'd9;
    step();
    bus.complete_long_i = 1'b1;
    bus.complete_dst_i  = 5'd9;
    #1;
    total++;
    if (bus.issue_ok_o !== 1'b1 || bus.block_id_o !== 1'b0) begin
      bad++; $display("FAIL same_cycle_issue got ok=%b blk=%b want ok=1 blk=0", bus.issue_ok_o, bus.block_id_o);
    end
    step();
    idle();
    bus.valid_id_i = 1'b1;
    set_src(0, 5'd9);
    #1;
    total++;
    if (bus.block_id_o !== 1'b1) begin
      bad++; $display("FAIL same_cycle_set_wins got=%b want=1", bus.block_id_o);
    end
    idle();
    bus.valid_id_i   = 1'b1;
    bus.issue_long_i = 1'b1;
    bus.issue_dst_i  = 5'd9;
    #1;
    total++;
    if (bus.block_id_o !== 1'b1 || bus.issue_ok_o !== 1'b0) begin
      bad++; $display("FAIL waw got blk=%b ok=%b want blk=1 ok=0", bus.block_id_o, bus.issue_ok_o);
    end
    idle();
    bus.complete_long_i = 1'b1;
    bus.complete_dst_i  = 5'd9;
    step();
    idle();
  endtask

  task automatic test_branch();
    idle();
    bus.valid_id_i     = 1'b1;
    set_src(0, 5'd7);
    set_stg(0, 5'd7, 1'b0);
    bus.issue_long_i   = 1'b1;
    bus.issue_dst_i    = 5'd3;
    bus.branch_taken_i = 1'b1;
    #1;
    total++;
    if ({bus.block_id_o, bus.inject_nops_id_o, bus.inject_nops_ex_o, bus.issue_ok_o} !== 4'b0110) begin
      bad++; $display("FAIL branch_flush got=%b want=0110",
                      {bus.block_id_o, bus.inject_nops_id_o, bus.inject_nops_ex_o, bus.issue_ok_o});
    end
    step();
    idle();
    bus.valid_id_i = 1'b1;
    set_src(1, 5'd3);
    #1;
    total++;
    if (bus.block_id_o !== 1'b0) begin
      bad++; $display("FAIL branch_no_issue got=%b want=0", bus.block_id_o);
    end
    idle();
  endtask

  task automatic test_icmiss_reset();
    idle();
    bus.valid_if_i = 1'b1;
    bus.ic_hit_i   = 1'b0;
    #1;
    total++;
    if ({bus.block_if_o, bus.inject_nops_id_o, bus.block_id_o} !== 3'b110) begin
      bad++; $display("FAIL icmiss_ctl got=%b want=110", {bus.block_if_o, bus.inject_nops_id_o, bus.block_id_o});
    end
    repeat (4) step();
    bus.ic_hit_i = 1'b1;
    #1;
    total++;
    if (bus.miss_cnt_o !== 4'd4) begin
      bad++; $display("FAIL icmiss_cnt got=%0d want=4", bus.miss_cnt_o);
    end
    total++;
    if (bus.stall_cnt_o !== CW'(exp_stall)) begin
      bad++; $display("FAIL stall_cnt got=%0d want=%0d", bus.stall_cnt_o, exp_stall);
    end
    idle();
    bus.valid_id_i   = 1'b1;
    bus.issue_long_i = 1'b1;
    bus.issue_dst_i  = 5'd9;
    step();
    idle();
    bus.valid_id_i = 1'b1;
    set_src(0, 5'd9);
    bus.valid_if_i = 1'b1;
    bus.ic_hit_i   = 1'b0;
    step();
    exp_stall++;
    total++;
    if (bus.block_id_o !== 1'b1 || bus.stall_cnt_o !== CW'(exp_stall) || bus.miss_cnt_o !== 4'd5) begin
      bad++; $display("FAIL pre_reset got blk=%b stall=%0d miss=%0d want blk=1 stall=%0d miss=5",
                      bus.block_id_o, bus.stall_cnt_o, bus.miss_cnt_o, exp_stall);
    end
    rst = 1'b1;
    #1;
    total++;
    if (bus.stall_cnt_o !== 4'd0 || bus.miss_cnt_o !== 4'd0) begin
      bad++; $display("FAIL reset_counters got stall=%0d miss=%0d want 0 0", bus.stall_cnt_o, bus.miss_cnt_o);
    end
    total++;
    if (bus.block_id_o !== 1'b0 || bus.block_if_o !== 1'b1) begin
      bad++; $display("FAIL reset_sb got blk_id=%b blk_if=%b want 0 1", bus.block_id_o, bus.block_if_o);
    end
    rst = 1'b0;
    exp_stall = 0;
    #1;
    total++;
    if (bus.block_id_o !== 1'b0) begin
      bad++; $display("FAIL reset_sb_after got=%b want=0", bus.block_id_o);
    end
    idle();
    step();
  endtask

  task automatic test_saturation();
    idle();
    bus.valid_id_i = 1'b1;
    set_src(0, 5'd7);
    set_stg(0, 5'd7, 1'b0);
    repeat (20) step();
    total++;
    if (bus.stall_cnt_o !== 4'hF) begin
      bad++; $display("FAIL stall_saturate got=%0d want=15", bus.stall_cnt_o);
    end
    idle();
    step();
    total++;
    if (bus.stall_cnt_o !== 4'hF) begin
      bad++; $display("FAIL stall_hold got=%0d want=15", bus.stall_cnt_o);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    exp_stall = 0;
    test_reset();
    test_fwd();
    test_load_use();
    test_scoreboard();
    test_same_cycle();
    test_branch();
    test_icmiss_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
